load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of MEM_WAIT cycles without mem_ack before the access is aborted (used only when LSU_TIMEOUT_EN is defined; legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid  input  1  the core presents an access.
REQ-005 The block SHALL have port req_ready  output  1  the unit accepts an access this cycle.
REQ-006 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 The block SHALL have port req_addr  input  32  byte address (ALU result).
REQ-009 The block SHALL have port req_wdata  input  32  store data (rs2).
REQ-010 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata  output  32  extended load data, 0 for stores and errors.
REQ-012 The block SHALL have port resp_err  output  1  misaligned, illegal funct3 or timeout; valid with resp_valid.
REQ-013 The block SHALL have ports mem_req/mem_we  output  1 each, mem_addr  output  32 (addr[1:0]=00), mem_be  output  4, mem_wdata  output  32, mem_ack  input  1, mem_rdata  input  32 (data-memory side).

Function
REQ-014 The block SHALL implement FSM states IDLE, MEM_WAIT and RESP; req_ready SHALL be 1 only in IDLE while rst=0.
REQ-015 Acceptance (req_valid & req_ready at a posedge) SHALL register all request fields; req_* inputs are don't-care outside acceptance.
REQ-016 At acceptance, the block SHALL flag an error for: load funct3 in {011,110,111}; store funct3 > 010; funct3 x01 with addr[0]=1; funct3 010 with addr[1:0]!=00.
REQ-017 An erroring request SHALL go IDLE->RESP, never assert mem_req, and produce resp_err=1, resp_rdata=0.
REQ-018 A legal request SHALL go IDLE->MEM_WAIT; in MEM_WAIT mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata SHALL stay constant until the cycle mem_ack=1 is sampled.
REQ-019 mem_be SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<{addr[1],1'b0} for half, 4'b1111 for word, for both loads and stores.
REQ-020 mem_wdata SHALL replicate the low byte (SB) in 4 lanes, the low half (SH) in 2 lanes, or pass the full word (SW).
REQ-021 On mem_ack the block SHALL capture the selected lane of mem_rdata: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified; then go to RESP.
REQ-022 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; minimum latency is acceptance edge +2 cycles to resp_valid (ack in the first MEM_WAIT cycle).
REQ-023 mem_ack sampled outside MEM_WAIT SHALL be ignored.
REQ-024 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from req_* or mem_* inputs to any output.

Reset
REQ-025 rst=1 SHALL force IDLE next edge with req_ready=0 during reset, and mem_req=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_* outputs=0 after reset.
REQ-026 rst asserted during MEM_WAIT or RESP SHALL abandon the access; no resp_valid SHALL be issued for it.

Configuration
REQ-027 With LSU_TIMEOUT_EN defined, a counter SHALL run in MEM_WAIT; after TIMEOUT_CYCLES cycles without ack, the block SHALL deassert mem_req and go to RESP with resp_err=1, resp_rdata=0. A late ack SHALL be ignored.
REQ-028 Without LSU_TIMEOUT_EN, MEM_WAIT SHALL wait for mem_ack indefinitely and no counter SHALL be synthesized.

Verification
REQ-029 Drive LB at addr 0x10000003 with mem_rdata=0x80FF7F01 and immediate ack -> mem_be=1000, resp_rdata=0xFFFFFF80, resp_err=0, resp_valid 2 cycles after acceptance.
REQ-030 Drive LHU at addr 0x10000002 with mem_rdata=0xBEEF1234 -> mem_be=1100, resp_rdata=0x0000BEEF.
REQ-031 Drive SB at addr 0x10000001 with req_wdata=0x123456AB and ack after 3 wait cycles -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB held stable for 4 cycles, then resp_valid.
REQ-032 Drive SW at addr 0x10000002 -> mem_req never asserted, resp_err=1, resp_rdata=0 one cycle after acceptance.
REQ-033 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, drive LW with no ack -> mem_req deasserts after 4 cycles, resp_err=1; a later ack produces no response.
REQ-034 Assert rst during MEM_WAIT of an LW -> mem_req=0 the next cycle, no resp_valid, req_ready=1 once rst is low.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit -- RV32I load/store unit between the core and a data memory.
//
// Accepts one access at a time, checks it for illegal width codes and
// misalignment, drives a word-aligned request with byte enables and
// lane-replicated store data, waits for mem_ack, then returns the
// extended load data in a one-cycle response pulse.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE, out of reset)
//   req_we, req_funct3       store flag and RV32I width/sign code
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error flag
//   mem_req, mem_we          memory request and write enable
//   mem_addr, mem_be         word-aligned address and byte enables
//   mem_wdata                lane-replicated store data
//   mem_ack, mem_rdata       memory acknowledge and read data
//
// Configuration:
//   LSU_TIMEOUT_EN  when defined, an access waiting TIMEOUT_CYCLES cycles
//                   without mem_ack is aborted with resp_err=1.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

  // Reject an out-of-range timeout at elaboration rather than silently wrapping the counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("load_store_unit: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addrLow_q;
  logic        memReq_q;
  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [3:0]  memBe_q;
  logic [31:0] memWdata_q;
  logic        respValid_q;
  logic        respErr_q;
  logic [31:0] respRdata_q;
`ifdef LSU_TIMEOUT_EN
  logic [15:0] waitCnt_q;
`endif

  logic        reqErr;
  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;

  // Decode the incoming request: legality, byte enables and lane-replicated
  // store data. Only consumed at the acceptance edge, so these never reach
  // an output combinationally.
  always_comb begin
    reqErr   = 1'b0;
    reqBe    = 4'b1111;
    reqWdata = req_wdata;
    if (req_we) begin
      if (req_funct3 > 3'b010) reqErr = 1'b1;
    end else begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) reqErr = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) reqErr = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) reqErr = 1'b1;
    case (req_funct3[1:0])
      2'b00: begin
        reqBe    = 4'b0001 << req_addr[1:0];
        reqWdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        reqBe    = 4'b0011 << {req_addr[1], 1'b0};
        reqWdata = {2{req_wdata[15:0]}};
      end
      default: begin
        reqBe    = 4'b1111;
        reqWdata = req_wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it according
  // to the registered width/sign code; the result is only captured on mem_ack.
  always_comb begin
    laneByte = 8'(mem_rdata >> {addrLow_q, 3'b000});
    laneHalf = 16'(mem_rdata >> {addrLow_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadData = {24'd0, laneByte};
      3'b101:  loadData = {16'd0, laneHalf};
      default: loadData = mem_rdata;
    endcase
  end

  // Main FSM. Every output is a register written here. The memory-side fields
  // are loaded once at acceptance and left untouched while waiting, which keeps
  // them stable until the ack. mem_ack only matters in MEM_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addrLow_q   <= 2'b00;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= 32'd0;
      memBe_q     <= 4'b0000;
      memWdata_q  <= 32'd0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      waitCnt_q   <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addrLow_q <= req_addr[1:0];
            if (reqErr) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
              respRdata_q <= 32'd0;
            end else begin
              state_q    <= MEM_WAIT;
              memReq_q   <= 1'b1;
              memWe_q    <= req_we;
              memAddr_q  <= {req_addr[31:2], 2'b00};
              memBe_q    <= reqBe;
              memWdata_q <= reqWdata;
`ifdef LSU_TIMEOUT_EN
              waitCnt_q  <= 16'd0;
`endif
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_q     <= RESP;
            memReq_q    <= 1'b0;
            respValid_q <= 1'b1;
            respErr_q   <= 1'b0;
            respRdata_q <= we_q ? 32'd0 : loadData;
          end
`ifdef LSU_TIMEOUT_EN
          // An ack arriving in the last allowed cycle still wins over the timeout.
          else if (waitCnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= RESP;
            memReq_q    <= 1'b0;
            respValid_q <= 1'b1;
            respErr_q   <= 1'b1;
            respRdata_q <= 32'd0;
          end else begin
            waitCnt_q <= waitCnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
          respErr_q   <= 1'b0;
          respRdata_q <= 32'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = respValid_q;
  assign resp_err   = respErr_q;
  assign resp_rdata = respRdata_q;
  assign mem_req    = memReq_q;
  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_be     = memBe_q;
  assign mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- self-checking bench for load_store_unit.
// Directed accesses plus a randomized sweep, each checked against a
// byte-lane reference model written with plain arithmetic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] lastRdata;
  logic [31:0] lastBe;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something in the run never returns.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned accSize(input logic [2:0] f3);
    logic [1:0] w;
    w = f3[1:0];
    return 32'd1 << w;
  endfunction

  function automatic bit modelErr(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (addr % accSize(f3)) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size, off;
    size = accSize(f3);
    off  = addr % 4;
    return 4'(((32'd1 << size) - 1) << off);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (accSize(f3))
      1:       return (wdata & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] modelRdata(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned val;
    int unsigned size, off;
    if (we) return 32'd0;
    size = accSize(f3);
    off  = addr % 4;
    val  = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
    if (!f3[2] && size < 4 && val >= (64'd1 << (8 * size - 1)))
      val = val - (64'd1 << (8 * size));
    return 32'(val);
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge; the unit must be ready.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    stepCycle();
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One whole access: acceptance, memory wait with ack after ackDelay extra
  // cycles, response pulse, and return to IDLE.
  task automatic runAccess(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ackDelay);
    bit err;
    err = modelErr(we, f3, addr);
    applyStimulus(tag, we, f3, addr, wdata);
    if (err) begin
      checkOutput({tag, " err mem_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, " err valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, " err flag"}, 32'(resp_err), 32'd1);
      checkOutput({tag, " err rdata"}, resp_rdata, 32'd0);
      lastRdata = resp_rdata;
    end else begin
      for (int w = 0; w <= ackDelay; w++) begin
        checkOutput({tag, " mem_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(we));
        checkOutput({tag, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput({tag, " mem_be"}, 32'(mem_be), 32'(modelBe(f3, addr)));
        if (we) checkOutput({tag, " mem_wdata"}, mem_wdata, modelWdata(f3, wdata));
        checkOutput({tag, " wait valid"}, 32'(resp_valid), 32'd0);
        lastBe    = 32'(mem_be);
        mem_ack   = (w == ackDelay);
        mem_rdata = (w == ackDelay) ? rdata : $urandom;
        stepCycle();
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      checkOutput({tag, " valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, " err"}, 32'(resp_err), 32'd0);
      checkOutput({tag, " rdata"}, resp_rdata, modelRdata(we, f3, addr, rdata));
      checkOutput({tag, " mem_req done"}, 32'(mem_req), 32'd0);
      lastRdata = resp_rdata;
    end
    stepCycle();
    checkOutput({tag, " pulse end"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, " ready again"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic        rWe;
    logic [2:0]  rF3;
    logic [31:0] rAddr;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    lastRdata  = 32'd0;
    lastBe     = 32'd0;

    $display("[TB] reset");
    stepCycle();
    stepCycle();
    checkOutput("ready in reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("ready after rst", 32'(req_ready), 32'd1);

    // Ack while idle must not produce anything.
    mem_ack = 1'b1;
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("idle ack valid", 32'(resp_valid), 32'd0);
    checkOutput("idle ack mem_req", 32'(mem_req), 32'd0);

    $display("[TB] directed accesses");
    runAccess("LB", 1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h80FF_7F01, 0);
    checkOutput("LB be const", lastBe, 32'b1000);
    checkOutput("LB rdata const", lastRdata, 32'hFFFF_FF80);

    runAccess("LHU", 1'b0, 3'b101, 32'h1000_0002, 32'h0, 32'hBEEF_1234, 1);
    checkOutput("LHU be const", lastBe, 32'b1100);
    checkOutput("LHU rdata const", lastRdata, 32'h0000_BEEF);

    runAccess("SB", 1'b1, 3'b000, 32'h1000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 3);
    checkOutput("SB be const", lastBe, 32'b0010);
    checkOutput("SB rdata const", lastRdata, 32'd0);

    runAccess("SW mis", 1'b1, 3'b010, 32'h1000_0002, 32'hCAFE_F00D, 32'h0, 0);
    runAccess("LH mis", 1'b0, 3'b001, 32'h1000_0001, 32'h0, 32'h0, 0);
    runAccess("SH ok", 1'b1, 3'b001, 32'h2000_0006, 32'h9999_A55A, 32'h0, 2);
    runAccess("LD ill", 1'b0, 3'b011, 32'h2000_0000, 32'h0, 32'h0, 0);
    runAccess("LW", 1'b0, 3'b010, 32'h2000_0008, 32'h0, 32'h8765_4321, 0);

    $display("[TB] reset during wait");
    applyStimulus("LW rst", 1'b0, 3'b010, 32'h3000_0000, 32'h0);
    checkOutput("LW rst mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    stepCycle();
    checkOutput("rst abort mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst abort ready", 32'(req_ready), 32'd0);
    rst     = 1'b0;
    mem_ack = 1'b1;
    #1;
    checkOutput("ready after abort", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("abort no resp", 32'(resp_valid), 32'd0);
    end
    mem_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus("LW to", 1'b0, 3'b010, 32'h4000_0010, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("to mem_req held", 32'(mem_req), 32'd1);
      stepCycle();
    end
    checkOutput("to mem_req drop", 32'(mem_req), 32'd0);
    checkOutput("to valid", 32'(resp_valid), 32'd1);
    checkOutput("to err", 32'(resp_err), 32'd1);
    checkOutput("to rdata", resp_rdata, 32'd0);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("late ack no resp", 32'(resp_valid), 32'd0);
    end
    mem_ack = 1'b0;
`else
    $display("[TB] long wait without timeout");
    applyStimulus("LW long", 1'b0, 3'b010, 32'h4000_0010, 32'h0);
    for (int k = 0; k < 20; k++) stepCycle();
    checkOutput("long mem_req held", 32'(mem_req), 32'd1);
    checkOutput("long no resp", 32'(resp_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    stepCycle();
    mem_ack = 1'b0;
    checkOutput("long valid", 32'(resp_valid), 32'd1);
    checkOutput("long rdata", resp_rdata, 32'h0BAD_F00D);
    stepCycle();
`endif

    $display("[TB] random accesses");
    for (int i = 0; i < 200; i++) begin
      rWe   = 1'($urandom);
      rF3   = 3'($urandom);
      rAddr = $urandom;
      if ($urandom_range(0, 3) != 0) rAddr = rAddr & ~(accSize(rF3) - 1);
      runAccess($sformatf("rnd%0d", i), rWe, rF3, rAddr, $urandom, $urandom,
                int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
